// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the data-memory request front-end: register/signal types,
// request struct, controller states and the address-window helpers.
package mem_access_ctrl_pkg;

  typedef logic [31:0] Register;
  typedef logic Signal;

  localparam Signal ENABLE  = 1'b1;
  localparam Signal DISABLE = 1'b0;

  localparam int MemAddrWidth = 16;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } MemOp;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } CtrlState;

  typedef struct packed {
    MemOp    op;
    Register addr;
    Register data;
  } MemReq;

  // Ones in the low w bits: the part of a word address that M decodes.
  function automatic Register addr_mask(input int unsigned w);
    Register m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      m[i] = (i < w);
    end
    return m;
  endfunction

  function automatic logic addr_out_of_range(input Register a, input int unsigned w);
    return |(a & ~addr_mask(w));
  endfunction

endpackage

// File: rtl/mem_access_ctrl_fifo.sv
// In-order request FIFO (mem_req_fifo) holding MemReq entries; a synchronous
// reset flushes it. Pushes while full and pops while empty are ignored.
module mem_req_fifo
  import mem_access_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push_i,
  input  MemReq din_i,
  input  logic  pop_i,
  output MemReq dout_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = PtrW + 1;

  MemReq            mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [CntW-1:0]  count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // Storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store front-end for data memory M: queues requests, issues them to M one
// at a time and returns load data. Define MEM_ACCESS_BOUNDS_CHECK_EN to reject addresses above ADDR_W.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int REQ_DEPTH = 4,
  parameter int ADDR_W    = MemAddrWidth
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     req_valid,
  output logic     req_ready,
  input  logic     req_op,
  input  Register  req_addr,
  input  Register  req_wdata,
  output logic     rsp_valid,
  input  logic     rsp_ready,
  output Register  rsp_data,
  output logic     rsp_err,
  output Register  mem_addr,
  output Signal    mem_read,
  output Signal    mem_write,
  output Register  mem_wdata,
  input  Register  mem_rdata,
  output CtrlState dbg_state
);

  localparam Register AddrMask = addr_mask(ADDR_W);

  // Handshakes: a transfer happens on a posedge where valid && ready; the
  // source holds its payload until then, and ready never depends on valid.
  MemReq    push_req;
  MemReq    head;
  logic     fifo_full;
  logic     fifo_empty;
  logic     push;
  logic     pop;
  logic     head_err;

  CtrlState state_q;
  MemOp     cur_op_q;
  logic     cur_err_q;
  Signal    mem_read_q;
  Signal    mem_write_q;
  Register  mem_addr_q;
  Register  mem_wdata_q;
  logic     rsp_valid_q;
  Register  rsp_data_q;
  logic     rsp_err_q;

  assign push_req = '{op: MemOp'(req_op), addr: req_addr, data: req_wdata};
  assign req_ready = !fifo_full && !reset;
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == IDLE) && !fifo_empty;

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
  assign head_err = addr_out_of_range(head.addr, ADDR_W);
`else
  assign head_err = 1'b0;
`endif

  mem_req_fifo #(
    .DEPTH(REQ_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (push_req),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Bus outputs are loaded at pop so they are valid for exactly the ACCESS cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_op_q    <= OP_LOAD;
      cur_err_q   <= 1'b0;
      mem_read_q  <= DISABLE;
      mem_write_q <= DISABLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q     <= ACCESS;
            cur_op_q    <= head.op;
            cur_err_q   <= head_err;
            mem_addr_q  <= head.addr & AddrMask;
            mem_read_q  <= (head.op == OP_LOAD && !head_err) ? ENABLE : DISABLE;
            mem_write_q <= (head.op == OP_STORE && !head_err) ? ENABLE : DISABLE;
            mem_wdata_q <= (head.op == OP_STORE && !head_err) ? head.data : '0;
          end
        end
        ACCESS: begin
          mem_read_q  <= DISABLE;
          mem_write_q <= DISABLE;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          if (cur_err_q) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
            state_q     <= RESP;
          end else if (cur_op_q == OP_LOAD) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= mem_rdata;
            state_q     <= RESP;
          end else begin
            state_q <= IDLE;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_read  = mem_read_q;
  // Reset gates the write strobe immediately so an aborted store never commits.
  assign mem_write = mem_write_q & ~reset;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: models memory M, drives directed and random
// requests, and scores load responses against a word-array reference model.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int AW        = MemAddrWidth;
  localparam int MEM_WORDS = 1 << AW;

  logic     clk = 1'b0;
  logic     reset;
  logic     req_valid;
  logic     req_ready;
  logic     req_op;
  Register  req_addr;
  Register  req_wdata;
  logic     rsp_valid;
  logic     rsp_ready;
  Register  rsp_data;
  logic     rsp_err;
  Register  mem_addr;
  Signal    mem_read;
  Signal    mem_write;
  Register  mem_wdata;
  Register  mem_rdata;
  CtrlState dbg_state;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .REQ_DEPTH(4),
    .ADDR_W   (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  // ---------------- memory M and reference model ----------------
  Register m_mem   [MEM_WORDS];
  Register ref_mem [MEM_WORDS];

  function automatic Register init_val(input int i);
    return {16'hC0DE ^ i[15:0], i[15:0]};
  endfunction

  assign mem_rdata = mem_read ? m_mem[mem_addr[AW-1:0]] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (mem_write) m_mem[mem_addr[AW-1:0]] = mem_wdata;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp_e;
  logic        prev_stall = 1'b0;
  Register     prev_data  = '0;
  bit          rand_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Expected behaviour from the request stream alone: every access is in order,
  // so a load sees all earlier stores; only the low AW bits select a word.
  function automatic void model_push(input logic op, input Register addr, input Register data,
                                     input bit commit);
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    if ((addr >> AW) != 0) begin
      exp_q.push_back({1'b1, 32'h0});
      return;
    end
`endif
    if (op == 1'b0) exp_q.push_back({1'b0, ref_mem[addr[AW-1:0]]});
    else if (commit) ref_mem[addr[AW-1:0]] = data;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", rsp_valid, 1);
        chk("hold_data", rsp_data, prev_data);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp actual=0x%08h required=no response", rsp_data);
        end else begin
          exp_e = exp_q.pop_front();
          chk("rsp_data", rsp_data, exp_e[31:0]);
          chk("rsp_err", rsp_err, exp_e[32]);
        end
      end
      if (!mem_read && !mem_write) begin
        chk("idle_bus", mem_addr | mem_wdata, 0);
      end else begin
        chk("one_cmd", mem_read & mem_write, 0);
        chk("addr_range", mem_addr >> AW, 0);
      end
      if (mem_read) rd_cnt++;
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic op, input Register addr, input Register data, input bit commit);
    bit ok = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = data;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    if (ok) begin
      model_push(op, addr, data, commit);
    end else begin
      checks++;
      errors++;
      $display("FAIL req_timeout actual=req_ready low required=accepted within 300 cycles");
    end
    cycle();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int idle_run = 0;
    bit ok = 0;
    rsp_ready = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && dbg_state == IDLE) idle_run++;
      else idle_run = 0;
      if (idle_run >= 3) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
    end
    cycle();
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_mem_rw"}, {mem_read, mem_write}, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_state"}, dbg_state, IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int cnt;
    int rd0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      m_mem[i]   = init_val(i);
      ref_mem[i] = init_val(i);
    end
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    cycle();
    reset = 1'b0;
    @(negedge clk);
    check_quiet("rst");
    chk("rst_release_ready", req_ready, 1);
    cycle();

    // store then load the same word
    send(1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 1);
    send(1'b0, 32'h0000_0005, '0, 1);
    drain();

    // isolated load: response visible in the cycle after push edge + 2
    send(1'b0, 32'h0000_0009, '0, 1);
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = n;
        break;
      end
    end
    chk("load_latency", lat, 3);
    drain();

    // isolated store: write strobe in the cycle after push edge + 1
    send(1'b1, 32'h0000_000A, 32'h0A0A_5050, 1);
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (mem_write) begin
        lat = n;
        break;
      end
    end
    chk("store_latency", lat, 2);
    chk("store_wdata", mem_wdata, 32'h0A0A_5050);
    drain();

    // backpressure: response held, later requests stay queued
    rsp_ready = 1'b0;
    send(1'b0, 32'h0000_0003, '0, 1);
    for (int n = 0; n < 20 && !rsp_valid; n++) @(negedge clk);
    cycle();
    send(1'b1, 32'h0000_0003, 32'h5555_AAAA, 1);
    send(1'b0, 32'h0000_0003, '0, 1);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_read || mem_write || !rsp_valid) cnt++;
    end
    chk("bp_stalled", cnt, 0);
    cycle();
    drain();

    // FIFO full: one request parked in RESP plus four queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(1'b0, Register'($urandom_range(0, 15)), '0, 1);
    @(negedge clk);
    chk("full_ready_low", req_ready, 0);
    chk("full_state_resp", dbg_state, RESP);
    cycle();
    rsp_ready = 1'b1;
    send(1'b1, 32'h0000_000B, 32'hB0B0_0001, 1);
    send(1'b0, 32'h0000_000B, '0, 1);
    drain();

    // reset while a store is in its ACCESS cycle
    send(1'b1, 32'h0000_0007, 32'h0000_1234, 0);
    cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_state", dbg_state, ACCESS);
    chk("rst_mid_no_write", mem_write, 0);
    cycle();
    reset = 1'b0;
    @(negedge clk);
    check_quiet("post_rst");
    cycle();
    send(1'b0, 32'h0000_0007, '0, 1);
    drain();

    // address aliasing / bounds check
    rd0 = rd_cnt;
    send(1'b0, 32'h0001_0002, '0, 1);
    drain();
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    chk("oor_mem_reads", rd_cnt - rd0, 0);
`else
    chk("alias_mem_reads", rd_cnt - rd0, 1);
`endif
    send(1'b1, 32'h0002_0004, 32'h4444_0002, 1);
    send(1'b0, 32'h0000_0004, '0, 1);
    drain();

    // idle bus
    repeat (20) begin
      @(negedge clk);
      chk("idle_quiet", {mem_read, mem_write, rsp_valid}, 0);
      chk("idle_addr", mem_addr, 0);
    end
    cycle();

    // randomized traffic with random response backpressure
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          Register a;
          Register up;
          a = Register'($urandom_range(0, 15));
          if ($urandom_range(0, 7) == 0) begin
            up = Register'($urandom_range(1, 3));
            a = a | (up << AW);
          end
          send(1'($urandom_range(0, 1)), a, Register'($urandom), 1);
          repeat ($urandom_range(0, 2)) cycle();
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          cycle();
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    chk("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
